rom_load_ctrl: RTL and testbench

Sequencer between the HPS ioctl download stream and the Time Pilot '84 ROM/PROM bank. It registers each download byte and tags it with a ROM region index for the chip-select fan-out. It also counts and validates the image size, holding the core in reset until a complete, in-range image has been written and a settle interval has elapsed. It sits on the download side of the bank, single clock domain.

---
 rtl/rom_load_ctrl_if.sv | 25 ++
 rtl/rom_load_ctrl.sv | 118 +++++++++++
 tb/tb_rom_load_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_load_ctrl_if.sv
// ioctl download stream in, registered ROM-bank write port and core status out.
interface rom_load_ctrl_if;
   logic        IOCTL_DOWNLOAD;
   logic [7:0]  IOCTL_INDEX;
   logic        IOCTL_WR;
   logic [24:0] IOCTL_ADDR;
   logic [7:0]  IOCTL_DOUT;
   logic [24:0] DL_ADDR;
   logic [7:0]  DL_DATA;
   logic        DL_WR;
   logic [4:0]  DL_REGION;
   logic        CORE_RESET;
   logic        ROM_READY;
   logic        LOAD_ERROR;

   modport master (
      output IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT,
      input  DL_ADDR, DL_DATA, DL_WR, DL_REGION, CORE_RESET, ROM_READY, LOAD_ERROR
   );

   modport slave (
      input  IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT,
      output DL_ADDR, DL_DATA, DL_WR, DL_REGION, CORE_RESET, ROM_READY, LOAD_ERROR
   );
endinterface

// File: rtl/rom_load_ctrl.sv
// Time Pilot '84 ROM download sequencer: registers ioctl bytes, tags ROM regions,
// validates image size and holds the core in reset until a good image has settled.
module rom_load_ctrl #(
   parameter int unsigned ROM_SIZE    = 'h18500,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input logic           CLK,
   input logic           RESET,
   rom_load_ctrl_if.slave io
);

   localparam logic [24:0] ROM_SIZE_W = 25'(ROM_SIZE);
   localparam logic [24:0] PROM_BASE  = 25'h18000;
   localparam int unsigned HW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, HOLD, RUN, ERROR} state_t;

   state_t        state;
   logic [24:0]   byte_count;
   logic          overflow;
   logic [HW-1:0] hold_count;
   logic [24:0]   dl_addr;
   logic [7:0]    dl_data;
   logic          dl_wr;
   logic [4:0]    dl_region;
   logic          core_reset;
   logic          rom_ready;
   logic          load_error;
   logic          dl_active;
   logic [4:0]    region_next;

   assign dl_active = io.IOCTL_DOWNLOAD && (io.IOCTL_INDEX == 8'd0);

   // EPROMs are 8 KiB each below 'h18000; the PROM/LUT area above uses 256-byte slots.
   always_comb begin
      region_next = '0;
      if (io.IOCTL_ADDR < PROM_BASE)
         region_next = {1'b0, io.IOCTL_ADDR[16:13]};
      else
         region_next = 5'd12 + {2'b00, io.IOCTL_ADDR[10:8]};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         byte_count <= '0;
         overflow   <= 1'b0;
         hold_count <= '0;
         dl_addr    <= '0;
         dl_data    <= '0;
         dl_wr      <= 1'b0;
         dl_region  <= '0;
         core_reset <= 1'b1;
         rom_ready  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         dl_wr <= 1'b0;
         case (state)
            IDLE, RUN, ERROR: begin
               if (dl_active) begin
                  state      <= LOAD;
                  byte_count <= '0;
                  overflow   <= 1'b0;
                  rom_ready  <= 1'b0;
                  load_error <= 1'b0;
                  core_reset <= 1'b1;
               end
            end
            LOAD: begin
               // A strobe on the cycle the download drops is still part of the image.
               if (io.IOCTL_WR) begin
                  if (io.IOCTL_ADDR < ROM_SIZE_W) begin
                     dl_addr   <= io.IOCTL_ADDR;
                     dl_data   <= io.IOCTL_DOUT;
                     dl_region <= region_next;
                     dl_wr     <= 1'b1;
                     if (byte_count != '1)
                        byte_count <= byte_count + 25'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               if (!dl_active)
                  state <= CHECK;
            end
            CHECK: begin
               if ((byte_count == ROM_SIZE_W) && !overflow) begin
                  state      <= HOLD;
                  hold_count <= HOLD_INIT;
               end else begin
                  state      <= ERROR;
                  load_error <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_count == '0) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  rom_ready  <= 1'b1;
               end else begin
                  hold_count <= hold_count - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.DL_ADDR    = dl_addr;
   assign io.DL_DATA    = dl_data;
   assign io.DL_WR      = dl_wr;
   assign io.DL_REGION  = dl_region;
   assign io.CORE_RESET = core_reset;
   assign io.ROM_READY  = rom_ready;
   assign io.LOAD_ERROR = load_error;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench: region decode table on a full-size instance, load sequencing on a
// scaled instance (256-byte image) so whole loads stay short.
module tb_rom_load_ctrl;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;
   int   oob_cnt = 0;
   int   data_bad = 0;

   rom_load_ctrl_if ifa ();
   rom_load_ctrl_if ifb ();

   rom_load_ctrl #(.ROM_SIZE('h100), .HOLD_CYCLES(16)) dut (
      .CLK(clk), .RESET(rst), .io(ifa)
   );

   rom_load_ctrl #(.ROM_SIZE('h18500), .HOLD_CYCLES(16)) dut_rg (
      .CLK(clk), .RESET(rst), .io(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (ifa.DL_WR === 1'b1) begin
         wr_cnt++;
         if (ifa.DL_ADDR >= 25'h100) oob_cnt++;
         if (ifa.DL_DATA !== ifa.DL_ADDR[7:0]) data_bad++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         ifa.IOCTL_WR = 1'b0;
      end
   endtask

   // Bytes 0..nbytes-1; returns with download just driven low (the falling cycle).
   task automatic do_load(input int unsigned nbytes, input bit wr_on_fall);
      int unsigned rdy_hi = 0;
      @(negedge clk);
      ifa.IOCTL_INDEX = 8'd0;
      ifa.IOCTL_DOWNLOAD = 1'b1;
      ifa.IOCTL_WR = 1'b0;
      @(negedge clk);
      check("core_reset_after_rise", 32'(ifa.CORE_RESET), 32'd1);
      check("state_load_after_rise", 32'(dut.state), 32'd1);
      for (int unsigned a = 0; a < nbytes - (wr_on_fall ? 1 : 0); a++) begin
         ifa.IOCTL_WR = 1'b1;
         ifa.IOCTL_ADDR = 25'(a);
         ifa.IOCTL_DOUT = 8'(a);
         @(negedge clk);
         if (ifa.ROM_READY) rdy_hi++;
      end
      check("ready_low_during_load", rdy_hi, 32'd0);
      ifa.IOCTL_DOWNLOAD = 1'b0;
      if (wr_on_fall) begin
         ifa.IOCTL_WR = 1'b1;
         ifa.IOCTL_ADDR = 25'(nbytes - 1);
         ifa.IOCTL_DOUT = 8'(nbytes - 1);
      end else begin
         ifa.IOCTL_WR = 1'b0;
      end
   endtask

   task automatic wait_release(output int unsigned k);
      k = 0;
      for (int unsigned i = 1; i <= 100; i++) begin
         @(negedge clk);
         ifa.IOCTL_WR = 1'b0;
         if (ifa.CORE_RESET == 1'b0) begin
            k = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic        wr;
      logic [24:0] addr;
      logic [7:0]  dout;
      logic        exp_wr;
      logic [24:0] exp_addr;
      logic [7:0]  exp_data;
      logic [4:0]  exp_region;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int unsigned k;
      int base;

      vecs[0] = '{1'b1, 25'h0,       8'h11, 1'b1, 25'h0,     8'h11, 5'd0};
      vecs[1] = '{1'b1, 25'h2000,    8'h22, 1'b1, 25'h2000,  8'h22, 5'd1};
      vecs[2] = '{1'b1, 25'h17FFF,   8'h33, 1'b1, 25'h17FFF, 8'h33, 5'd11};
      vecs[3] = '{1'b1, 25'h18000,   8'h44, 1'b1, 25'h18000, 8'h44, 5'd12};
      vecs[4] = '{1'b1, 25'h18100,   8'h55, 1'b1, 25'h18100, 8'h55, 5'd13};
      vecs[5] = '{1'b1, 25'h184FF,   8'h66, 1'b1, 25'h184FF, 8'h66, 5'd16};
      vecs[6] = '{1'b1, 25'h18500,   8'h77, 1'b0, 25'h184FF, 8'h66, 5'd16};
      vecs[7] = '{1'b0, 25'h0,       8'h00, 1'b0, 25'h184FF, 8'h66, 5'd16};
      vecs[8] = '{1'b1, 25'h1FFFFFF, 8'h88, 1'b0, 25'h184FF, 8'h66, 5'd16};
      vecs[9] = '{1'b1, 25'hA000,    8'h99, 1'b1, 25'hA000,  8'h99, 5'd5};

      rst = 1'b1;
      ifa.IOCTL_DOWNLOAD = 1'b0; ifa.IOCTL_INDEX = '0; ifa.IOCTL_WR = 1'b0;
      ifa.IOCTL_ADDR = '0; ifa.IOCTL_DOUT = '0;
      ifb.IOCTL_DOWNLOAD = 1'b0; ifb.IOCTL_INDEX = '0; ifb.IOCTL_WR = 1'b0;
      ifb.IOCTL_ADDR = '0; ifb.IOCTL_DOUT = '0;
      repeat (3) @(negedge clk);

      check("rst_state", 32'(dut.state), 32'd0);
      check("rst_core_reset", 32'(ifa.CORE_RESET), 32'd1);
      check("rst_rom_ready", 32'(ifa.ROM_READY), 32'd0);
      check("rst_load_error", 32'(ifa.LOAD_ERROR), 32'd0);
      check("rst_dl_wr", 32'(ifa.DL_WR), 32'd0);
      check("rst_dl_addr", 32'(ifa.DL_ADDR), 32'd0);
      check("rst_dl_data", 32'(ifa.DL_DATA), 32'd0);
      check("rst_dl_region", 32'(ifa.DL_REGION), 32'd0);
      check("rst_count", 32'(dut.byte_count), 32'd0);
      rst = 1'b0;
      idle(3);
      check("idle_core_reset", 32'(ifa.CORE_RESET), 32'd1);

      // Region decode and range drop, back-to-back strobes on the full-size instance
      @(negedge clk);
      ifb.IOCTL_DOWNLOAD = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         ifb.IOCTL_WR = vecs[i].wr;
         ifb.IOCTL_ADDR = vecs[i].addr;
         ifb.IOCTL_DOUT = vecs[i].dout;
         @(negedge clk);
         check($sformatf("vec%0d_wr", i), 32'(ifb.DL_WR), 32'(vecs[i].exp_wr));
         check($sformatf("vec%0d_addr", i), 32'(ifb.DL_ADDR), 32'(vecs[i].exp_addr));
         check($sformatf("vec%0d_data", i), 32'(ifb.DL_DATA), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_region", i), 32'(ifb.DL_REGION), 32'(vecs[i].exp_region));
      end
      ifb.IOCTL_WR = 1'b0;
      ifb.IOCTL_DOWNLOAD = 1'b0;
      repeat (3) @(negedge clk);
      check("rg_overrun_error", 32'(ifb.LOAD_ERROR), 32'd1);
      check("rg_core_reset", 32'(ifb.CORE_RESET), 32'd1);

      // Full load
      base = wr_cnt;
      do_load(256, 1'b0);
      wait_release(k);
      check("full_release_cycles", k, 32'd18);
      check("full_rom_ready", 32'(ifa.ROM_READY), 32'd1);
      check("full_load_error", 32'(ifa.LOAD_ERROR), 32'd0);
      check("full_pulses", 32'(wr_cnt - base), 32'd256);

      // Non-zero index download during RUN is ignored
      base = wr_cnt;
      @(negedge clk);
      ifa.IOCTL_INDEX = 8'd1;
      ifa.IOCTL_DOWNLOAD = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ifa.IOCTL_WR = 1'b1;
         ifa.IOCTL_ADDR = 25'(i);
         ifa.IOCTL_DOUT = 8'(i);
         @(negedge clk);
      end
      ifa.IOCTL_WR = 1'b0;
      ifa.IOCTL_DOWNLOAD = 1'b0;
      ifa.IOCTL_INDEX = 8'd0;
      idle(2);
      check("idx1_pulses", 32'(wr_cnt - base), 32'd0);
      check("idx1_state_run", 32'(dut.state), 32'd4);
      check("idx1_core_reset", 32'(ifa.CORE_RESET), 32'd0);
      check("idx1_rom_ready", 32'(ifa.ROM_READY), 32'd1);

      // Reload from RUN, final byte on the falling cycle
      base = wr_cnt;
      do_load(256, 1'b1);
      wait_release(k);
      check("reload_release_cycles", k, 32'd18);
      check("reload_rom_ready", 32'(ifa.ROM_READY), 32'd1);
      check("reload_pulses", 32'(wr_cnt - base), 32'd256);

      // Short load
      base = wr_cnt;
      do_load(255, 1'b0);
      idle(4);
      check("short_state_error", 32'(dut.state), 32'd5);
      check("short_load_error", 32'(ifa.LOAD_ERROR), 32'd1);
      check("short_rom_ready", 32'(ifa.ROM_READY), 32'd0);
      check("short_pulses", 32'(wr_cnt - base), 32'd255);
      idle(20);
      check("short_core_reset_held", 32'(ifa.CORE_RESET), 32'd1);

      // Overrun by one byte
      base = wr_cnt;
      do_load(257, 1'b0);
      idle(4);
      check("over_load_error", 32'(ifa.LOAD_ERROR), 32'd1);
      check("over_core_reset", 32'(ifa.CORE_RESET), 32'd1);
      check("over_pulses", 32'(wr_cnt - base), 32'd256);
      check("over_no_oob_write", 32'(oob_cnt), 32'd0);

      // Recovery after error
      do_load(256, 1'b0);
      wait_release(k);
      check("recover_release_cycles", k, 32'd18);
      check("recover_load_error", 32'(ifa.LOAD_ERROR), 32'd0);

      // Reset in the middle of a load
      @(negedge clk);
      ifa.IOCTL_DOWNLOAD = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         ifa.IOCTL_WR = 1'b1;
         ifa.IOCTL_ADDR = 25'(i);
         ifa.IOCTL_DOUT = 8'(i);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_state", 32'(dut.state), 32'd0);
      check("midrst_core_reset", 32'(ifa.CORE_RESET), 32'd1);
      check("midrst_rom_ready", 32'(ifa.ROM_READY), 32'd0);
      check("midrst_dl_wr", 32'(ifa.DL_WR), 32'd0);
      check("midrst_count", 32'(dut.byte_count), 32'd0);
      base = wr_cnt;
      rst = 1'b0;
      ifa.IOCTL_DOWNLOAD = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ifa.IOCTL_WR = 1'b1;
         ifa.IOCTL_ADDR = 25'(20 + i);
         @(negedge clk);
      end
      ifa.IOCTL_WR = 1'b0;
      idle(2);
      check("midrst_no_more_wr", 32'(wr_cnt - base), 32'd0);
      check("midrst_idle", 32'(dut.state), 32'd0);
      check("data_matches_addr", 32'(data_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
